// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port instruction/data memory between
// the fetch stage and the load/store stage. At most one transaction is
// granted per idle cycle; reads have a fixed latency of LAT cycles and the
// returned word is routed back to whichever port issued the read.
//
// Optional build macro MEM_ARB_RR_EN: round-robin priority between the two
// ports when both request in the same idle cycle. Without it, data always
// wins over fetch (it belongs to the older instruction).
//
// state   | meaning
// IDLE    | free; grants combinationally in the cycle a request is seen
// RD_WAIT | read outstanding; counter runs down to the data return cycle

module mem_port_arbiter #(
   parameter int LAT = 2,
   parameter int AW  = 32
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [31:0]   if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [3:0]    d_be,
   input  logic [AW-1:0] d_addr,
   input  logic [31:0]   d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [31:0]   d_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [3:0]    mem_be,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata
);

   typedef enum logic {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } state_t;

   localparam logic [2:0] LAT_C = 3'(LAT);

   state_t      state_q;
   logic [2:0]  cnt_q;
   logic        owner_q;
   logic        if_rvalid_q;
   logic        d_rvalid_q;
   logic [31:0] if_rdata_q;
   logic [31:0] d_rdata_q;

   logic        idle_ok;
   logic        pick_d;
   logic        gnt_if;
   logic        gnt_d;

`ifdef MEM_ARB_RR_EN
   // Holds the port granted most recently (0 = fetch, 1 = data).
   logic        rr_q;
`endif

   // Grant decision; grants are suppressed while reset is asserted so that
   // all outputs drop to zero immediately, even with requests pending.
   always_comb begin
      idle_ok = nrst && (state_q == IDLE);
`ifdef MEM_ARB_RR_EN
      pick_d  = d_req && (!if_req || !rr_q);
`else
      pick_d  = d_req;
`endif
      gnt_d   = idle_ok && pick_d;
      gnt_if  = idle_ok && if_req && !pick_d;
   end

   // Memory port mux driven from the granted requester.
   always_comb begin
      mem_en    = gnt_d || gnt_if;
      mem_we    = 1'b0;
      mem_be    = 4'b0000;
      mem_addr  = '0;
      mem_wdata = '0;
      if (gnt_d) begin
         mem_we    = d_we;
         mem_be    = d_we ? d_be : 4'b1111;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end else if (gnt_if) begin
         mem_be    = 4'b1111;
         mem_addr  = if_addr;
      end
   end

   // Sequencer: launches reads, counts down the latency, captures the return.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= IDLE;
         cnt_q       <= 3'd0;
         owner_q     <= 1'b0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         if_rdata_q  <= 32'd0;
         d_rdata_q   <= 32'd0;
      end else begin
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (gnt_d && !d_we) begin
                  state_q <= RD_WAIT;
                  cnt_q   <= LAT_C;
                  owner_q <= 1'b1;
               end else if (gnt_if) begin
                  state_q <= RD_WAIT;
                  cnt_q   <= LAT_C;
                  owner_q <= 1'b0;
               end
            end
            RD_WAIT: begin
               cnt_q <= cnt_q - 3'd1;
               // Counter hits zero on this edge: memory data is valid now.
               if (cnt_q == 3'd1) begin
                  state_q <= IDLE;
                  if (owner_q) begin
                     d_rdata_q  <= mem_rdata;
                     d_rvalid_q <= 1'b1;
                  end else begin
                     if_rdata_q  <= mem_rdata;
                     if_rvalid_q <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef MEM_ARB_RR_EN
   // Round-robin pointer follows every grant, contested or not.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         rr_q <= 1'b0;
      end else if (gnt_d || gnt_if) begin
         rr_q <= gnt_d;
      end
   end
`endif

   assign if_gnt    = gnt_if;
   assign d_gnt     = gnt_d;
   assign if_rvalid = if_rvalid_q;
   assign d_rvalid  = d_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares one single-port instruction/data memory between the fetch stage and the load/store stage of the MIPS core. Grants at most one transaction per idle cycle, tracks fixed-latency read returns and routes read data back to the requester. Sits between the PC/fetch logic and data-access logic (driven by the decoder's `read_mem`/`write_mem`) on one side and the memory macro on the other.

## Interface
- `LAT`, 2, memory read latency in cycles, legal 1..7; `mem_rdata` is valid exactly `LAT` cycles after the `mem_en` cycle.
- `AW`, 32, address width.
- `clk` input 1: single clock, rising edge.
- `nrst` input 1: asynchronous, active-low reset.
- `if_req` input 1: fetch request, held until `if_gnt`.
- `if_addr` input AW: fetch address.
- `if_gnt` output 1: fetch accepted this cycle.
- `if_rvalid` output 1: one-cycle pulse when `if_rdata` is valid.
- `if_rdata` output 32: fetched word.
- `d_req` input 1: data request, held until `d_gnt`.
- `d_we` input 1: 1 = store, 0 = load.
- `d_be` input 4: byte enables for SB/SH/SW; ignored on loads.
- `d_addr` input AW: data address.
- `d_wdata` input 32: store data.
- `d_gnt` output 1: data request accepted this cycle.
- `d_rvalid` output 1: one-cycle pulse when `d_rdata` is valid (loads only).
- `d_rdata` output 32: loaded word.
- `mem_en`, `mem_we` output 1 each; `mem_be` output 4; `mem_addr` output AW; `mem_wdata` output 32; `mem_rdata` input 32.

## Operation
- States: IDLE, RD_WAIT. A 3-bit latency counter and an owner flag (`0` = fetch, `1` = data) are kept.
- IDLE, no request: all memory outputs 0 except address/data, which are don't-care.
- IDLE, request present: grant combinationally in the same cycle. `mem_en`=1. Address, `we`, `be` and `wdata` come from the granted port.
- Fetch grant drives `mem_we`=0 and `mem_be`=4'b1111.
- Both requesting: data wins, because it belongs to the older instruction. See Configuration for the alternative.
- Store grant: stay in IDLE. The next request can be granted the following cycle. No `rvalid` is produced for a store.
- Load or fetch grant: go to RD_WAIT, load counter with `LAT`, record the owner.
- RD_WAIT: no grants, `mem_en`=0, counter decrements each cycle.
  - When the counter reaches 0, capture `mem_rdata` into the owner's rdata register on that clock edge.
  - Pulse the owner's `rvalid` for the following cycle and return to IDLE.
- `if_rdata`/`d_rdata` hold their last value until the next read for that port overwrites them.
- Requests asserted during RD_WAIT wait. Requesters must keep `req` and its fields stable until granted.

## Timing
- Grant latency: 0 cycles from `req` in IDLE.
- Read: grant in cycle T. Memory returns data in T+`LAT`. `rvalid`=1 in T+`LAT`+1, and IDLE may grant again in that same cycle.
- Read throughput: one read per `LAT`+1 cycles. Stores: one per cycle.
- Reset values: `if_gnt`, `d_gnt`, `if_rvalid`, `d_rvalid`, `mem_en`, `mem_we` = 0; `mem_be` = 0; `if_rdata`, `d_rdata` = 0; state IDLE; counter 0; owner 0; RR pointer 0.
- Reset mid-read: the outstanding read is dropped immediately and no `rvalid` follows. Requesters reissue after `nrst` deasserts.
- `rvalid` and `gnt` to the same port may be high in the same cycle.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin priority when both ports request in IDLE.
  - A 1-bit pointer favours the port not granted most recently.
  - The pointer updates on every grant, including uncontested grants.
- Not defined: fixed priority with data over fetch, and no pointer flop.

## Test plan
- Single fetch, `LAT`=2: `if_req` with `if_addr`=0x40 at T, memory returns 0x2008000A at T+2 -> `if_gnt`=1 at T, `mem_en`=1/`mem_be`=4'hF at T, `if_rvalid`=1 with `if_rdata`=0x2008000A at T+3.
- Simultaneous requests, macro off: `if_req` and `d_req` (load, addr 0x100) at T -> `d_gnt` at T, `if_gnt` at T+3, `d_rvalid` at T+3.
- Back-to-back SB stores: `d_we`=1, `d_be`=4'b0010 at T and T+1 -> `d_gnt` and `mem_we`=1 with `mem_be`=4'b0010 in both cycles, and no `d_rvalid`.
- Round-robin, macro on: both ports request continuously -> grant sequence alternates data, fetch, data, fetch.
- Reset mid-read: fetch granted at T, `nrst` low at T+1 -> all outputs 0 immediately, and no `if_rvalid` at T+3.
- Request during RD_WAIT: `d_req` raised at T+1 while a fetch is outstanding from T -> `d_gnt` at T+3, not before.
